// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int WEIGHT_W_DEF = 4;

   typedef logic [WEIGHT_W_DEF-1:0] weight_t;

   // Index width that stays at least one bit wide for degenerate client counts.
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or above ptr_i, wrapping.
// excl_i removes a client from the search unless it is the only requester.
module rr_pick
   import arb_pkg::*;
#(
   parameter int CLIENTS = 4,
   parameter int IDW     = idw(CLIENTS)
)(
   input  logic [CLIENTS-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   input  logic [CLIENTS-1:0] excl_i,
   output logic [CLIENTS-1:0] pick_o,
   output logic [IDW-1:0]     idx_o,
   output logic               any_o
);

   logic [CLIENTS-1:0]   masked;
   logic [CLIENTS-1:0]   eff;
   logic [CLIENTS-1:0]   thermo;
   logic [2*CLIENTS-1:0] dbl;
   logic                 found;
   int                   pos;
   int                   sel;

   // Lower half keeps only bits at/above ptr; upper half is the unmasked wrap-around copy.
   always_comb begin
      masked = req_i & ~excl_i;
      eff    = (|masked) ? masked : req_i;
      thermo = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         thermo[i] = (i >= int'(ptr_i));
      end
      dbl   = {eff, eff & thermo};
      found = 1'b0;
      pos   = 0;
      for (int i = 0; i < 2*CLIENTS; i++) begin
         if (!found && dbl[i]) begin
            found = 1'b1;
            pos   = i;
         end
      end
      sel    = (pos >= CLIENTS) ? pos - CLIENTS : pos;
      pick_o = '0;
      if (found) begin
         pick_o[sel] = 1'b1;
      end
      idx_o = IDW'(sel);
      any_o = |eff;
   end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter granting a shared burst sink per burst,
// with credit-limited back-to-back ownership and an idle-owner watchdog.
//
//   state    | meaning
//   ARB_IDLE | no owner, gnt = 0, picker armed on any req
//   ARB_BUSY | one owner, gnt held until burst end or watchdog release
module wrr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int CLIENTS  = 4,
   parameter int WEIGHT_W = 4,
   parameter int TIMEOUT  = 16
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CLIENTS-1:0]          req_i,
   input  logic [CLIENTS-1:0]          req_last_i,
   input  logic [CLIENTS*WEIGHT_W-1:0] weight_i,
   input  logic                        m_ready_i,
   output logic [CLIENTS-1:0]          gnt_o,
   output logic                        m_valid_o,
   output logic                        m_last_o,
   output logic [idw(CLIENTS)-1:0]     owner_id_o,
   output logic                        timeout_err_o
);

   localparam int IDW   = idw(CLIENTS);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [CLIENTS-1:0]  gnt_q, gnt_d;
   logic [IDW-1:0]      owner_q, owner_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [WEIGHT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    idle_q, idle_d;
   logic                tout_q, tout_d;

   logic [CLIENTS-1:0]  pick;
   logic [IDW-1:0]      pick_idx;
   logic                pick_any;
   logic [WEIGHT_W-1:0] pick_w;
   logic [WEIGHT_W-1:0] reload;
   logic [WEIGHT_W-1:0] credit_dec;
   logic [IDW-1:0]      next_ptr;
   logic                owner_req;
   logic                m_valid;
   logic                m_last;
   logic                burst_end;
   logic                wd_fire;
   logic                handover;
   logic                take;

   // The owner is always excluded from a re-pick unless it is the only requester.
   rr_pick #(.CLIENTS(CLIENTS), .IDW(IDW)) u_pick (
      .req_i  (req_i),
      .ptr_i  (ptr_q),
      .excl_i (gnt_q),
      .pick_o (pick),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   assign pick_w     = weight_i[pick_idx*WEIGHT_W +: WEIGHT_W];
   assign reload     = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
   assign credit_dec = (credit_q == '0) ? '0 : credit_q - WEIGHT_W'(1);
   assign next_ptr   = (pick_idx == IDW'(CLIENTS - 1)) ? '0 : pick_idx + IDW'(1);
   assign owner_req  = req_i[owner_q];
   assign burst_end  = m_valid & m_ready_i & m_last;
   assign wd_fire    = (TIMEOUT > 0) && (state_q == ARB_BUSY) && !owner_req && (idle_q == IDLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
         idle_q   <= '0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         idle_q   <= idle_d;
         tout_q   <= tout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      idle_d   = idle_q;
      tout_d   = 1'b0;
      handover = 1'b0;
      take     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            idle_d = '0;
            take   = pick_any;
         end
         ARB_BUSY: begin
            if (burst_end) begin
               if (credit_dec != '0) begin
                  credit_d = credit_dec;
                  idle_d   = '0;
               end else begin
                  handover = 1'b1;
               end
            end else if (wd_fire) begin
               handover = 1'b1;
               tout_d   = 1'b1;
            end else if (owner_req) begin
               idle_d = '0;
            end else if (idle_q != IDLE_MAX) begin
               idle_d = idle_q + CNT_W'(1);
            end
            if (handover) begin
               take = pick_any;
               if (!pick_any) begin
                  state_d  = ARB_IDLE;
                  gnt_d    = '0;
                  credit_d = '0;
                  idle_d   = '0;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
      if (take) begin
         state_d  = ARB_BUSY;
         gnt_d    = pick;
         owner_d  = pick_idx;
         ptr_d    = next_ptr;
         credit_d = reload;
         idle_d   = '0;
      end
   end

   always_comb begin
      m_valid = |(gnt_q & req_i);
      m_last  = m_valid & req_last_i[owner_q];
   end

   assign gnt_o         = gnt_q;
   assign m_valid_o     = m_valid;
   assign m_last_o      = m_last;
   assign owner_id_o    = owner_q;
   assign timeout_err_o = tout_q;

   a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
   a_stable : assert property (@(posedge clk) disable iff (!rst_n)
                               (state_q == ARB_BUSY && !burst_end && !wd_fire) |=> $stable(gnt_q));
   a_valid  : assert property (@(posedge clk) disable iff (!rst_n) m_valid |-> (|gnt_q));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: vector table, directed corner cases,
// and randomized traffic against an arithmetic reference model.
module tb_wrr_burst_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  req_last = '0;
   logic [N*WW-1:0] weight = '0;
   logic          m_ready = 1'b0;
   logic [N-1:0]  gnt;
   logic          m_valid;
   logic          m_last;
   logic [1:0]    owner_id;
   logic          tout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wrr_burst_arbiter #(.CLIENTS(N), .WEIGHT_W(WW), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (req),
      .req_last_i    (req_last),
      .weight_i      (weight),
      .m_ready_i     (m_ready),
      .gnt_o         (gnt),
      .m_valid_o     (m_valid),
      .m_last_o      (m_last),
      .owner_id_o    (owner_id),
      .timeout_err_o (tout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
      req      = r;
      req_last = l;
      m_ready  = rd;
      #1;
   endtask

   task automatic set_w(input int w0, input int w1, input int w2, input int w3);
      weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; req_last = '0; m_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Reference model: plain integers following the arbitration rules.
   int mb, mown, mptr, mcred, midle, mtout;

   task automatic model_reset();
      mb = 0; mown = 0; mptr = 0; mcred = 0; midle = 0; mtout = 0;
   endtask

   function automatic int model_pick(input logic [N-1:0] r, input int p, input int excl);
      logic [N-1:0] e;
      logic [N-1:0] m;
      e = r;
      if (excl >= 0) begin
         m = r;
         m[excl] = 1'b0;
         if (m != '0) e = m;
      end
      for (int i = 0; i < N; i++) begin
         if (e[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic model_grant(input int n);
      int w;
      if (n < 0) begin
         mb = 0; mcred = 0; midle = 0;
      end else begin
         w = int'(weight[n*WW +: WW]);
         mb = 1; mown = n; mptr = (n + 1) % N;
         mcred = (w == 0) ? 1 : w;
         midle = 0;
      end
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
      int nt;
      nt = 0;
      if (mb != 0) begin
         if (r[mown] && rd && l[mown]) begin
            if (mcred - 1 > 0) begin
               mcred = mcred - 1;
               midle = 0;
            end else begin
               model_grant(model_pick(r, mptr, mown));
            end
         end else if (!r[mown]) begin
            if (midle == TO - 1) begin
               nt = 1;
               model_grant(model_pick(r, mptr, mown));
            end else begin
               midle++;
            end
         end else begin
            midle = 0;
         end
      end else begin
         model_grant(model_pick(r, mptr, -1));
      end
      mtout = nt;
   endtask

   typedef struct {
      logic [N-1:0] r;
      logic [N-1:0] l;
      logic         rd;
      logic [N-1:0] g;
      logic         v;
      logic         ml;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got timeout expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int bc[N];
      int exp_seq[16];
      int beats, bubbles, started, guard;
      int waitc[N];
      int maxw;
      int dens;
      logic [N-1:0] l;
      logic [N-1:0] r;
      logic rd;
      logic [N-1:0] eg;
      logic ev, el;
      logic sawt;

      // weights 1 throughout the table
      tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
      tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0};
      tbl[7]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0};
      tbl[8]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1};
      tbl[9]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1};
      tbl[10] = '{4'b1000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0};
      tbl[11] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1};
      tbl[12] = '{4'b0101, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0};
      tbl[13] = '{4'b0101, 4'b0101, 1'b1, 4'b0010, 1'b0, 1'b0};

      // reset values, even with requests present
      set_w(1, 1, 1, 1);
      rst_n = 1'b0;
      drive(4'b1111, 4'b1111, 1'b1);
      tick();
      check("reset_state", {gnt, owner_id, tout, m_valid, m_last}, 32'h0);
      rst_n = 1'b1;
      drive(4'b0001, 4'b0000, 1'b1);
      check("first_req_no_gnt", {gnt, m_valid}, {4'b0000, 1'b0});
      tick();
      check("first_gnt", {gnt, owner_id, m_valid}, {4'b0001, 2'd0, 1'b1});
      #2 rst_n = 1'b0;
      #1 check("async_reset", {gnt, m_valid, owner_id}, 32'h0);
      #1 rst_n = 1'b1;

      // vector table
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].r, tbl[i].l, tbl[i].rd);
         check($sformatf("table_row%0d", i), {gnt, m_valid, m_last}, {tbl[i].g, tbl[i].v, tbl[i].ml});
         tick();
      end

      // weight 3 on client 0, 2-beat bursts from clients 0 and 1
      do_reset();
      set_w(3, 1, 1, 1);
      exp_seq = '{0,0,0,0,0,0,1,1,0,0,0,0,0,0,1,1};
      for (int k = 0; k < N; k++) bc[k] = 0;
      beats = 0; bubbles = 0; started = 0; guard = 0;
      while (beats < 16 && guard < 100) begin
         l = '0;
         for (int k = 0; k < N; k++) l[k] = (bc[k] == 1);
         drive(4'b0011, l, 1'b1);
         if (m_valid) begin
            check($sformatf("wt_beat%0d_owner", beats), 32'(owner_id), 32'(exp_seq[beats]));
            bc[owner_id] = bc[owner_id] ^ 1;
            beats++;
            started = 1;
         end else if (started != 0) begin
            bubbles++;
         end
         tick();
         guard++;
      end
      check("wt_beats_done", beats, 16);
      check("wt_bubbles", bubbles, 0);

      // watchdog: owner silent for TIMEOUT cycles while client 2 waits
      do_reset();
      set_w(1, 1, 1, 1);
      drive(4'b0001, 4'b0000, 1'b1);
      tick();
      for (int i = 0; i < TO; i++) begin
         drive(4'b0100, 4'b0000, 1'b1);
         check($sformatf("wd_hold%0d", i), {gnt, tout}, {4'b0001, 1'b0});
         tick();
      end
      check("wd_release", {gnt, owner_id, tout}, {4'b0100, 2'd2, 1'b1});
      drive(4'b0100, 4'b0000, 1'b1);
      tick();
      check("wd_pulse_one_cycle", {gnt, tout}, {4'b0100, 1'b0});

      // owner silent one cycle short of the threshold
      do_reset();
      drive(4'b0001, 4'b0000, 1'b1);
      tick();
      sawt = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
         drive(4'b0100, 4'b0000, 1'b1);
         tick();
         sawt |= tout;
      end
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 4'b0000, 1'b1);
         tick();
         sawt |= tout;
      end
      check("wd15_no_release", {gnt, sawt}, {4'b0001, 1'b0});

      // downstream stall with contending clients
      do_reset();
      drive(4'b0001, 4'b0000, 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(4'b1111, 4'b0000, 1'b0);
         check($sformatf("stall%0d", i), {gnt, m_valid}, {4'b0001, 1'b1});
         tick();
      end
      drive(4'b1111, 4'b0001, 1'b1);
      check("stall_last", {gnt, m_valid, m_last}, {4'b0001, 1'b1, 1'b1});
      tick();
      drive(4'b1111, 4'b0000, 1'b1);
      check("stall_handover", {gnt, owner_id}, {4'b0010, 2'd1});

      // weight 0 behaves as 1 for a sole requester
      do_reset();
      set_w(1, 0, 1, 1);
      drive(4'b0010, 4'b0010, 1'b1);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(4'b0010, 4'b0010, 1'b1);
         check($sformatf("w0_regrant%0d", i), {gnt, m_valid, m_last}, {4'b0010, 1'b1, 1'b1});
         tick();
      end

      // randomized traffic against the reference model
      maxw = 0;
      for (int ph = 0; ph < 4; ph++) begin
         set_w($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
         do_reset();
         model_reset();
         for (int k = 0; k < N; k++) waitc[k] = 0;
         dens = (ph == 0) ? 7 : (ph == 1) ? 4 : (ph == 2) ? 1 : 6;
         for (int c = 0; c < 700; c++) begin
            for (int k = 0; k < N; k++) begin
               r[k] = ($urandom_range(0, 7) < dens);
               l[k] = ($urandom_range(0, 2) == 0);
            end
            rd = (ph == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(r, l, rd);
            eg = (mb != 0) ? N'(1 << mown) : '0;
            ev = (mb != 0) && r[mown];
            el = ev && l[mown];
            check("rand_cycle", {gnt, owner_id, m_valid, m_last, tout},
                  {eg, 2'(mown), ev, el, 1'(mtout)});
            for (int k = 0; k < N; k++) begin
               waitc[k] = (r[k] && !gnt[k]) ? waitc[k] + 1 : 0;
               if (waitc[k] > maxw) maxw = waitc[k];
            end
            model_step(r, l, rd);
            tick();
         end
      end
      check("rand_max_wait_over_600", 32'(maxw > 600), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
